axi_sram_slave: RTL and testbench

- AXI4 slave memory model sitting directly downstream of the core's AXI master interface; it consumes the AR/R/AW/W/B channels that the master drives.
- Backs an internal word-addressed SRAM array and supports FIXED and INCR bursts.
- Separate read and write FSMs run concurrently, with a configurable read latency.
- Used as the simulation/FPGA memory behind the shared AXI bus.

---
 rtl/axi_sram_slave.sv | 353 +++++++++++++++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// -----------------------------------------------------------------------------
// axi_sram_slave
//
// AXI4 slave memory model backed by a word-addressed SRAM array. It serves
// FIXED and INCR bursts. WRAP bursts are handled as INCR. Independent read and
// write FSMs run concurrently, and reads have a configurable latency.
//
// Optional feature (macro AXI_SRAM_RAND_DELAY_EN):
//   When this macro is defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11,
//   seed 16'hACE1) adds 0..3 cycles to the read latency. It can also drop
//   rvalid_o for one cycle between read beats, to stress master handshakes.
//   When the macro is undefined, latency is fixed, beats run back-to-back,
//   and no LFSR logic is built.
//
// Ports
//   clk_i, rst_ni                       clock, async active-low reset
//   ar*  (arvalid_i/arready_o/...)      read address channel
//   r*   (rvalid_o/rready_i/...)        read data channel
//   aw*  (awvalid_i/awready_o/...)      write address channel
//   w*   (wvalid_i/wready_o/...)        write data channel
//   b*   (bvalid_o/bready_i/...)        write response channel
//
// The word index is addr[OFF +: log2(MEM_DEPTH)], where OFF = log2(STRB_WIDTH).
// Higher address bits are ignored, so accesses alias modulo the memory size.
// A burst with burst type 2'b11, or with a size wider than the bus, runs its
// full beat count and answers SLVERR. Such a read returns zero data, and such
// a write never updates the memory.
// -----------------------------------------------------------------------------
module axi_sram_slave #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int MEM_DEPTH  = 1024,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  // AR channel
  input  logic                  arvalid_i,
  output logic                  arready_o,
  input  logic [3:0]            arid_i,
  input  logic [ADDR_WIDTH-1:0] araddr_i,
  input  logic [7:0]            arlen_i,
  input  logic [2:0]            arsize_i,
  input  logic [1:0]            arburst_i,
  // R channel
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic [3:0]            rid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [1:0]            rresp_o,
  output logic                  rlast_o,
  // AW channel
  input  logic                  awvalid_i,
  output logic                  awready_o,
  input  logic [3:0]            awid_i,
  input  logic [ADDR_WIDTH-1:0] awaddr_i,
  input  logic [7:0]            awlen_i,
  input  logic [2:0]            awsize_i,
  input  logic [1:0]            awburst_i,
  // W channel
  input  logic                  wvalid_i,
  output logic                  wready_o,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [STRB_WIDTH-1:0] wstrb_i,
  input  logic                  wlast_i,
  // B channel
  output logic                  bvalid_o,
  input  logic                  bready_i,
  output logic [3:0]            bid_o,
  output logic [1:0]            bresp_o
);

  localparam int OFF   = $clog2(STRB_WIDTH);
  localparam int IDX_W = $clog2(MEM_DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [2:0]            size,
    input logic [1:0]            burst
  );
    if (burst == BURST_FIXED) return addr;
    // INCR; WRAP deliberately follows the same linear stepping.
    return addr + (ADDR_WIDTH'(1) << size);
  endfunction

  function automatic logic cfg_err(input logic [2:0] size, input logic [1:0] burst);
    return (burst == BURST_RSVD) || (32'(size) > 32'(OFF));
  endfunction

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // ---------------------------------------------------------------------------
  // Random delay source (optional)
  // ---------------------------------------------------------------------------
  logic [4:0] lat_load;
  logic       gap;

`ifdef AXI_SRAM_RAND_DELAY_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr <= 16'hACE1;
    else         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign lat_load = 5'(RD_LATENCY - 1) + 5'(lfsr[1:0]);
  assign gap      = lfsr[2];
`else
  assign lat_load = 5'(RD_LATENCY - 1);
  assign gap      = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  r_state_t              r_state;
  logic                  arready;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [3:0]            rid;
  logic [1:0]            rresp;
  logic                  rlast;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_err;
  logic [7:0]            r_beat;
  logic [4:0]            lat_cnt;

  logic [ADDR_WIDTH-1:0] r_next;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      r_next_idx;
  logic [7:0]            r_beat_inc;

  assign r_next     = next_addr(r_addr, r_size, r_burst);
  assign r_idx      = r_addr[OFF +: IDX_W];
  assign r_next_idx = r_next[OFF +: IDX_W];
  assign r_beat_inc = r_beat + 8'd1;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values and block order cannot create races.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rid     <= '0;
      rresp   <= RESP_OKAY;
      rlast   <= 1'b0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_err   <= 1'b0;
      r_beat  <= '0;
      lat_cnt <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arready && arvalid_i) begin
            rid     <= arid_i;
            r_addr  <= araddr_i;
            r_len   <= arlen_i;
            r_size  <= arsize_i;
            r_burst <= arburst_i;
            r_err   <= cfg_err(arsize_i, arburst_i);
            lat_cnt <= lat_load;
            r_beat  <= '0;
            arready <= 1'b0;
            r_state <= R_WAIT;
          end else begin
            arready <= 1'b1;
          end
        end

        R_WAIT: begin
          if (lat_cnt == '0) begin
            rvalid  <= 1'b1;
            rdata   <= r_err ? '0 : mem[r_idx];
            rresp   <= r_err ? RESP_SLVERR : RESP_OKAY;
            rlast   <= (r_len == 8'd0);
            r_state <= R_DATA;
          end else begin
            lat_cnt <= lat_cnt - 5'd1;
          end
        end

        R_DATA: begin
          if (!rvalid) begin
            // Reload after an inserted gap cycle; the address has already advanced.
            rvalid <= 1'b1;
            rdata  <= r_err ? '0 : mem[r_idx];
            rlast  <= (r_beat == r_len);
          end else if (rready_i) begin
            if (r_beat == r_len) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_addr <= r_next;
              r_beat <= r_beat_inc;
              if (gap) begin
                rvalid <= 1'b0;
                rlast  <= 1'b0;
              end else begin
                // Reads the pre-edge array, so a same-edge write is not seen.
                rdata <= r_err ? '0 : mem[r_next_idx];
                rlast <= (r_beat_inc == r_len);
              end
            end
          end
        end

        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign arready_o = arready;
  assign rvalid_o  = rvalid;
  assign rdata_o   = rdata;
  assign rid_o     = rid;
  assign rresp_o   = rresp;
  assign rlast_o   = rlast;

  // ---------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------
  w_state_t              w_state;
  logic                  awready;
  logic                  wready;
  logic                  bvalid;
  logic [3:0]            bid;
  logic [1:0]            bresp;
  logic [3:0]            w_id;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic                  w_err;
  logic [7:0]            w_beat;

  logic                  w_hs;
  logic                  w_final;
  logic                  wlast_bad;
  logic                  mem_we;
  logic [IDX_W-1:0]      w_idx;

  assign w_hs      = (w_state == W_DATA) && wready && wvalid_i;
  assign w_final   = (w_beat == w_len);
  assign wlast_bad = (wlast_i != w_final);
  // Once a burst is known to be bad, no beat of it reaches the array.
  assign mem_we    = w_hs && !w_err && !wlast_bad;
  assign w_idx     = w_addr[OFF +: IDX_W];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= RESP_OKAY;
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
      w_beat  <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (awready && awvalid_i) begin
            w_id    <= awid_i;
            w_addr  <= awaddr_i;
            w_len   <= awlen_i;
            w_size  <= awsize_i;
            w_burst <= awburst_i;
            w_err   <= cfg_err(awsize_i, awburst_i);
            w_beat  <= '0;
            awready <= 1'b0;
            wready  <= 1'b1;
            w_state <= W_DATA;
          end else begin
            awready <= 1'b1;
          end
        end

        W_DATA: begin
          if (w_hs) begin
            w_addr <= next_addr(w_addr, w_size, w_burst);
            w_beat <= w_beat + 8'd1;
            if (wlast_bad) w_err <= 1'b1;
            // The counted beat number, not wlast_i, ends the burst.
            if (w_final) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bid     <= w_id;
              bresp   <= (w_err || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
              w_state <= W_RESP;
            end
          end
        end

        W_RESP: begin
          if (bready_i) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end

        default: w_state <= W_IDLE;
      endcase
    end
  end

  // NOTE: the array has no reset; contents survive rst_ni, and leaving it out
  // keeps the array mappable onto block RAM.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (wstrb_i[b]) mem[w_idx][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  assign awready_o = awready;
  assign wready_o  = wready;
  assign bvalid_o  = bvalid;
  assign bid_o     = bid;
  assign bresp_o   = bresp;

endmodule

// File: tb/tb_axi_sram_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_sram_slave
//
// Directed self-checking bench for axi_sram_slave. Expected R beats and B
// responses are queued when a transaction is issued. They are popped and
// compared when the DUT presents them. Outputs are sampled on the negedge.
// Inputs are driven 1 time unit after the posedge.
// -----------------------------------------------------------------------------
module tb_axi_sram_slave;

  localparam int DW     = 64;
  localparam int AW     = 32;
  localparam int SW     = DW / 8;
  localparam int RD_LAT = 2;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] INCR   = 2'b01;

  logic          clk_i;
  logic          rst_ni;
  logic          arvalid_i, arready_o;
  logic [3:0]    arid_i;
  logic [AW-1:0] araddr_i;
  logic [7:0]    arlen_i;
  logic [2:0]    arsize_i;
  logic [1:0]    arburst_i;
  logic          rvalid_o, rready_i;
  logic [3:0]    rid_o;
  logic [DW-1:0] rdata_o;
  logic [1:0]    rresp_o;
  logic          rlast_o;
  logic          awvalid_i, awready_o;
  logic [3:0]    awid_i;
  logic [AW-1:0] awaddr_i;
  logic [7:0]    awlen_i;
  logic [2:0]    awsize_i;
  logic [1:0]    awburst_i;
  logic          wvalid_i, wready_o;
  logic [DW-1:0] wdata_i;
  logic [SW-1:0] wstrb_i;
  logic          wlast_i;
  logic          bvalid_o, bready_i;
  logic [3:0]    bid_o;
  logic [1:0]    bresp_o;

  axi_sram_slave #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .MEM_DEPTH (1024),
    .RD_LATENCY(RD_LAT)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .arvalid_i(arvalid_i),
    .arready_o(arready_o),
    .arid_i   (arid_i),
    .araddr_i (araddr_i),
    .arlen_i  (arlen_i),
    .arsize_i (arsize_i),
    .arburst_i(arburst_i),
    .rvalid_o (rvalid_o),
    .rready_i (rready_i),
    .rid_o    (rid_o),
    .rdata_o  (rdata_o),
    .rresp_o  (rresp_o),
    .rlast_o  (rlast_o),
    .awvalid_i(awvalid_i),
    .awready_o(awready_o),
    .awid_i   (awid_i),
    .awaddr_i (awaddr_i),
    .awlen_i  (awlen_i),
    .awsize_i (awsize_i),
    .awburst_i(awburst_i),
    .wvalid_i (wvalid_i),
    .wready_o (wready_o),
    .wdata_i  (wdata_i),
    .wstrb_i  (wstrb_i),
    .wlast_i  (wlast_i),
    .bvalid_o (bvalid_o),
    .bready_i (bready_i),
    .bid_o    (bid_o),
    .bresp_o  (bresp_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
    logic [3:0]    id;
  } rexp_t;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;

  rexp_t rq[$];
  bexp_t bq[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic exp_r(input logic [3:0] id, input logic [DW-1:0] data,
                       input logic [1:0] resp, input logic last);
    rexp_t e;
    e.data = data; e.resp = resp; e.last = last; e.id = id;
    rq.push_back(e);
  endtask

  task automatic aw_send(input logic [3:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    awvalid_i = 1'b1; awid_i = id; awaddr_i = addr; awlen_i = len;
    awsize_i = size; awburst_i = burst;
    @(negedge clk_i);
    while (!awready_o && n < 50) begin @(negedge clk_i); n++; end
    if (!awready_o) check("aw_ready_timeout", awready_o, 1);
    tick();
    awvalid_i = 1'b0;
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, output int c0);
    int n = 0;
    arvalid_i = 1'b1; arid_i = id; araddr_i = addr; arlen_i = len;
    arsize_i = size; arburst_i = burst;
    @(negedge clk_i);
    while (!arready_o && n < 50) begin @(negedge clk_i); n++; end
    if (!arready_o) check("ar_ready_timeout", arready_o, 1);
    tick();
    c0 = cyc;
    arvalid_i = 1'b0;
  endtask

  task automatic w_beat(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic last);
    int n = 0;
    wvalid_i = 1'b1; wdata_i = d; wstrb_i = s; wlast_i = last;
    @(negedge clk_i);
    while (!wready_o && n < 50) begin @(negedge clk_i); n++; end
    if (!wready_o) check("w_ready_timeout", wready_o, 1);
    tick();
    wvalid_i = 1'b0; wlast_i = 1'b0;
  endtask

  task automatic b_wait();
    int n = 0;
    bexp_t e;
    bready_i = 1'b1;
    @(negedge clk_i);
    while (!bvalid_o && n < 50) begin @(negedge clk_i); n++; end
    if (!bvalid_o) begin
      check("b_timeout", bvalid_o, 1);
    end else if (bq.size() == 0) begin
      check("b_unexpected", bvalid_o, 0);
    end else begin
      e = bq.pop_front();
      check("bid", bid_o, e.id);
      check("bresp", bresp_o, e.resp);
    end
    tick();
    bready_i = 1'b0;
  endtask

  // Collects nbeats R beats. With toggle set, rready follows 1,0,1,0 across
  // the cycles where rvalid is seen, so held beats are checked as well.
  task automatic r_collect(input int nbeats, input bit toggle, input int c0, output int lat);
    int    got   = 0;
    int    n     = 0;
    int    k     = 0;
    bit    first = 1'b1;
    rexp_t e;
    lat = -1;
    while (got < nbeats && n < 200) begin
      rready_i = toggle ? (k % 2 == 0) : 1'b1;
      @(negedge clk_i);
      if (rvalid_o) begin
        if (first) begin lat = cyc - c0; first = 1'b0; end
        if (rq.size() == 0) begin
          check("r_unexpected", rvalid_o, 0);
        end else begin
          e = rq[0];
          check("rdata", rdata_o, e.data);
          check("rresp", rresp_o, e.resp);
          check("rlast", rlast_o, e.last);
          check("rid", rid_o, e.id);
          if (rready_i) begin
            void'(rq.pop_front());
            got++;
          end
        end
        k++;
      end
      tick();
      n++;
    end
    rready_i = 1'b0;
    check("r_beats", got, nbeats);
  endtask

  task automatic wr(input logic [3:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                    input logic [2:0] size, input logic [1:0] burst,
                    input logic [DW-1:0] d [4], input logic [SW-1:0] s [4],
                    input logic [3:0] lmask, input logic [1:0] eresp);
    bexp_t e;
    e.id = id; e.resp = eresp;
    bq.push_back(e);
    aw_send(id, addr, len, size, burst);
    for (int i = 0; i <= int'(len); i++) w_beat(d[i], s[i], lmask[i]);
    b_wait();
  endtask

  task automatic wr1(input logic [3:0] id, input logic [AW-1:0] addr,
                     input logic [DW-1:0] d, input logic [SW-1:0] s);
    wr(id, addr, 8'd0, 3'd3, INCR, '{d, 64'h0, 64'h0, 64'h0}, '{s, 8'h0, 8'h0, 8'h0},
       4'b0001, OKAY);
  endtask

  task automatic rd(input logic [3:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                    input logic [2:0] size, input logic [1:0] burst, input bit toggle,
                    output int lat);
    int c0;
    ar_send(id, addr, len, size, burst, c0);
    r_collect(int'(len) + 1, toggle, c0, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int c0;

    arvalid_i = 0; arid_i = 0; araddr_i = 0; arlen_i = 0; arsize_i = 0; arburst_i = 0;
    rready_i  = 0;
    awvalid_i = 0; awid_i = 0; awaddr_i = 0; awlen_i = 0; awsize_i = 0; awburst_i = 0;
    wvalid_i  = 0; wdata_i = 0; wstrb_i = 0; wlast_i = 0;
    bready_i  = 0;

    // Reset held for 3 cycles: all outputs low.
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_arready", arready_o, 0);
    check("rst_awready", awready_o, 0);
    check("rst_wready", wready_o, 0);
    check("rst_rvalid", rvalid_o, 0);
    check("rst_bvalid", bvalid_o, 0);
    check("rst_rbus", {rdata_o, rid_o, rresp_o, rlast_o}, '0);
    check("rst_bbus", {bid_o, bresp_o}, '0);
    rst_ni = 1'b1;
    tick();
    check("post_rst_arready", arready_o, 1);
    check("post_rst_awready", awready_o, 1);
    check("post_rst_rvalid", rvalid_o, 0);
    check("post_rst_bvalid", bvalid_o, 0);

    // Single write, then read back with latency measurement.
    wr1(4'h3, 32'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF);
    exp_r(4'h5, 64'h1122_3344_5566_7788, OKAY, 1'b1);
    rd(4'h5, 32'h8000_0010, 8'd0, 3'd3, INCR, 1'b0, lat);
    check("rd_latency", lat, RD_LAT);

    // Strobe merge.
    wr1(4'h1, 32'h40, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    wr1(4'h2, 32'h40, 64'h0, 8'h0F);
    exp_r(4'h1, 64'hFFFF_FFFF_0000_0000, OKAY, 1'b1);
    rd(4'h1, 32'h40, 8'd0, 3'd3, INCR, 1'b0, lat);

    // INCR burst write, then read back with rready toggling.
    wr(4'h9, 32'h100, 8'd3, 3'd3, INCR, '{64'd1, 64'd2, 64'd3, 64'd4},
       '{8'hFF, 8'hFF, 8'hFF, 8'hFF}, 4'b1000, OKAY);
    for (int i = 1; i <= 4; i++) exp_r(4'hA, 64'(i), OKAY, i == 4);
    rd(4'hA, 32'h100, 8'd3, 3'd3, INCR, 1'b1, lat);

    // FIXED burst re-reads the same word.
    exp_r(4'hB, 64'd1, OKAY, 1'b0);
    exp_r(4'hB, 64'd1, OKAY, 1'b1);
    rd(4'hB, 32'h100, 8'd1, 3'd3, FIXED, 1'b0, lat);

    // Reserved burst type: one SLVERR beat with zero data.
    exp_r(4'hC, 64'h0, SLVERR, 1'b1);
    rd(4'hC, 32'h100, 8'd0, 3'd3, 2'b11, 1'b0, lat);

    // Oversized beat: two SLVERR beats.
    exp_r(4'hD, 64'h0, SLVERR, 1'b0);
    exp_r(4'hD, 64'h0, SLVERR, 1'b1);
    rd(4'hD, 32'h100, 8'd1, 3'd4, INCR, 1'b0, lat);

    // Early wlast: SLVERR after both beats, memory untouched.
    wr(4'h4, 32'h300, 8'd1, 3'd3, INCR, '{64'hAAAA, 64'hBBBB, 64'h0, 64'h0},
       '{8'hFF, 8'hFF, 8'h0, 8'h0}, 4'b0010, OKAY);
    wr(4'h6, 32'h300, 8'd1, 3'd3, INCR, '{64'h1111, 64'h2222, 64'h0, 64'h0},
       '{8'hFF, 8'hFF, 8'h0, 8'h0}, 4'b0001, SLVERR);
    exp_r(4'h7, 64'hAAAA, OKAY, 1'b0);
    exp_r(4'h7, 64'hBBBB, OKAY, 1'b1);
    rd(4'h7, 32'h300, 8'd1, 3'd3, INCR, 1'b0, lat);

    // Aliased read of word 0 whose data load shares an edge with a write to word 0.
    wr1(4'h8, 32'h0, 64'h5555_0000_1234, 8'hFF);
    exp_r(4'h6, 64'h5555_0000_1234, OKAY, 1'b1);
    begin
      bexp_t e;
      e.id = 4'h7; e.resp = OKAY;
      bq.push_back(e);
    end
    arvalid_i = 1'b1; arid_i = 4'h6; araddr_i = 32'h2000; arlen_i = 8'd0;
    arsize_i = 3'd3; arburst_i = INCR;
    awvalid_i = 1'b1; awid_i = 4'h7; awaddr_i = 32'h0; awlen_i = 8'd0;
    awsize_i = 3'd3; awburst_i = INCR;
    @(negedge clk_i);
    check("conc_arready", arready_o, 1);
    check("conc_awready", awready_o, 1);
    tick();
    c0 = cyc;
    arvalid_i = 1'b0;
    awvalid_i = 1'b0;
    repeat (RD_LAT - 1) tick();
    wvalid_i = 1'b1; wdata_i = 64'hAB; wstrb_i = 8'hFF; wlast_i = 1'b1;
    @(negedge clk_i);
    check("conc_wready", wready_o, 1);
    tick();
    wvalid_i = 1'b0; wlast_i = 1'b0;
    r_collect(1, 1'b0, c0, lat);
    check("conc_latency", lat, RD_LAT);
    b_wait();

    // Later reads see the new value, through both the direct and the aliased address.
    exp_r(4'h2, 64'hAB, OKAY, 1'b1);
    rd(4'h2, 32'h0, 8'd0, 3'd3, INCR, 1'b0, lat);
    exp_r(4'h3, 64'hAB, OKAY, 1'b1);
    rd(4'h3, 32'h2000, 8'd0, 3'd3, INCR, 1'b0, lat);

    check("rq_drained", rq.size(), 0);
    check("bq_drained", bq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
